// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings and FSM state type for the multicycle ALU
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SLT  = 3'b100,
        OP_SLTU = 3'b101,
        OP_MUL  = 3'b110,
        OP_XOR  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - adder with optional B inversion and carry-in, exposing carry and signed overflow
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             invert_b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] low;
    logic [1:0]       top;

    assign b_eff = invert_b ? ~b : b;

    // Split at the MSB so the carry into the sign bit is visible for overflow.
    assign low = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
               + {{(WIDTH-1){1'b0}}, carry_in};
    assign top = {1'b0, a[WIDTH-1]} + {1'b0, b_eff[WIDTH-1]} + {1'b0, low[WIDTH-1]};

    assign sum       = {top[0], low[WIDTH-2:0]};
    assign carry_out = top[1];
    assign overflow  = top[1] ^ low[WIDTH-1];

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - ALU with single-cycle logic/arith ops and a WIDTH-cycle shift-add multiplier
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_e           state, state_nxt;
    op_e              op_sel;
    logic             accept;
    logic [WIDTH-1:0] as_sum;
    logic             as_cout, as_ovf, as_sub;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic [CW-1:0]    mul_cnt;
    logic [WIDTH-1:0] mul_acc, mul_mcand, mul_mplier, mul_acc_nxt;

    assign op_sel = op_e'(op);
    assign accept = in_valid & in_ready;
    assign as_sub = (op_sel != OP_ADD);

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a         (a),
        .b         (b),
        .invert_b  (as_sub),
        .carry_in  (as_sub),
        .sum       (as_sum),
        .carry_out (as_cout),
        .overflow  (as_ovf)
    );

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_sel)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_ADD, OP_SUB: begin
                alu_res = as_sum;
                alu_c   = as_cout;
                alu_v   = as_ovf;
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~as_cout};
            default: alu_res = '0;
        endcase
    end

    assign mul_acc_nxt = mul_acc + (mul_mplier[0] ? mul_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = (op_sel == OP_MUL) ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_cnt == LAST_STEP) state_nxt = ST_DONE;
            ST_DONE: begin
                if (accept)         state_nxt = (op_sel == OP_MUL) ? ST_MUL : ST_DONE;
                else if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
        out_valid = (state == ST_DONE);
        busy      = (state == ST_MUL);
    end

    // Result and flags only change at an accept or on the final multiply step,
    // so they stay put while a result waits for out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= '0;
            zero       <= 1'b1;
            carry_out  <= 1'b0;
            overflow   <= 1'b0;
            mul_cnt    <= '0;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
        end else if (accept) begin
            if (op_sel == OP_MUL) begin
                mul_mcand  <= a;
                mul_mplier <= b;
                mul_acc    <= '0;
                mul_cnt    <= '0;
            end else begin
                result    <= alu_res;
                zero      <= (alu_res == '0);
                carry_out <= alu_c;
                overflow  <= alu_v;
            end
        end else if (state == ST_MUL) begin
            mul_acc    <= mul_acc_nxt;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + CW'(1);
            if (mul_cnt == LAST_STEP) begin
                result    <= mul_acc_nxt;
                zero      <= (mul_acc_nxt == '0);
                carry_out <= 1'b0;
                overflow  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle at WIDTH=8
module tb_alu_multicycle;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero, carry_out, overflow, busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    // Reference: returns {result, zero, carry_out, overflow} from plain integer arithmetic.
    function automatic logic [10:0] model(input logic [2:0] f_op, input logic [7:0] x, input logic [7:0] y);
        int unsigned ux, uy, full;
        int          sx, sy;
        logic [7:0]  r;
        logic        c, v;
        ux = x; uy = y;
        sx = $signed(x); sy = $signed(y);
        c = 1'b0; v = 1'b0; full = 0;
        case (f_op)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: begin
                full = ux + uy; r = full[7:0]; c = full[8];
                v = (sx + sy > 127) || (sx + sy < -128);
            end
            3'd3: begin
                full = ux + (255 - uy) + 1; r = full[7:0]; c = full[8];
                v = (sx - sy > 127) || (sx - sy < -128);
            end
            3'd4: r = (sx < sy) ? 8'd1 : 8'd0;
            3'd5: r = (ux < uy) ? 8'd1 : 8'd0;
            3'd6: begin full = ux * uy; r = full[7:0]; end
            default: r = x ^ y;
        endcase
        return {r, (r == 8'd0), c, v};
    endfunction

    function automatic logic [7:0] pick_operand();
        case ($urandom_range(0, 4))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic drive(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, result, zero, carry_out, overflow} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got rdy=%b ov=%b busy=%b res=%h z=%b c=%b v=%b exp rdy=1 ov=0 busy=0 res=00 z=1 c=0 v=0",
                     in_ready, out_valid, busy, result, zero, carry_out, overflow);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_overflow();
        @(negedge clk);
        drive(3'd2, 8'h7F, 8'h01); out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result, zero, carry_out, overflow} !== {1'b1, 8'h80, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL add_7f_01 got ov=%b res=%h z=%b c=%b v=%b exp ov=1 res=80 z=0 c=0 v=1",
                     out_valid, result, zero, carry_out, overflow);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_return_idle got out_valid=%b exp 0", out_valid);
        end
    endtask

    task automatic test_sub_slt();
        drive(3'd3, 8'h05, 8'h05); out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if ({out_valid, result, zero, carry_out, overflow} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sub_5_5 got ov=%b res=%h z=%b c=%b v=%b exp ov=1 res=00 z=1 c=1 v=0",
                     out_valid, result, zero, carry_out, overflow);
        end
        drive(3'd4, 8'hFF, 8'h01);
        @(posedge clk); @(negedge clk);
        checks++;
        if ({out_valid, result, carry_out, overflow} !== {1'b1, 8'h01, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL slt_ff_01 got ov=%b res=%h c=%b v=%b exp ov=1 res=01 c=0 v=0",
                     out_valid, result, carry_out, overflow);
        end
        drive(3'd5, 8'hFF, 8'h01);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result, zero, carry_out, overflow} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL sltu_ff_01 got ov=%b res=%h z=%b c=%b v=%b exp ov=1 res=00 z=1 c=0 v=0",
                     out_valid, result, zero, carry_out, overflow);
        end
        @(negedge clk);
    endtask

    task automatic test_mul();
        int bad;
        bad = 0;
        drive(3'd6, 8'h0D, 8'h0B); out_ready = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if ({busy, in_ready, out_valid} !== 3'b100) bad++;
            drive(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mul_busy_window got %0d bad cycles exp 0 (busy=1 in_ready=0 out_valid=0 for 8 cycles)", bad);
        end
        @(negedge clk);
        checks++;
        if ({busy, out_valid, result, zero, carry_out, overflow} !== {1'b0, 1'b1, 8'h8F, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mul_0d_0b got busy=%b ov=%b res=%h z=%b c=%b v=%b exp busy=0 ov=1 res=8f z=0 c=0 v=0",
                     busy, out_valid, result, zero, carry_out, overflow);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        drive(3'd0, 8'hF0, 8'h3C); out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ({out_valid, in_ready, result, zero} !== {1'b1, 1'b0, 8'h30, 1'b0}) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_hold got %0d bad cycles exp 0 (res=30 held, in_ready=0)", bad);
        end
        out_ready = 1'b1;
        drive(3'd1, 8'h0F, 8'hF0);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_in_ready got %b exp 1", in_ready);
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result, zero} !== {1'b1, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL or_no_bubble got ov=%b res=%h z=%b exp ov=1 res=ff z=0", out_valid, result, zero);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        bad = 0;
        drive(3'd6, 8'hA7, 8'h5B); out_ready = 1'b1;
        @(posedge clk);
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, in_ready, result, zero, carry_out, overflow} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_mul got ov=%b busy=%b rdy=%b res=%h z=%b c=%b v=%b exp ov=0 busy=0 rdy=1 res=00 z=1 c=0 v=0",
                     out_valid, busy, in_ready, result, zero, carry_out, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'd2, 8'h03, 8'h04);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result, zero} !== {1'b1, 8'h07, 1'b0}) begin
            failures++;
            $display("FAIL first_accept_after_reset got ov=%b res=%h z=%b exp ov=1 res=07 z=0", out_valid, result, zero);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if ({out_valid, busy} !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL no_stale_result got %0d cycles with out_valid/busy set exp 0", bad);
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [7:0]  x, y;
        logic [10:0] exp_v;
        int          lat, stall, bad;
        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 7));
            x = pick_operand(); y = pick_operand();
            exp_v = model(o, x, y);
            drive(o, x, y); out_ready = 1'b0;
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            checks++;
            if (lat != ((o == 3'd6) ? 9 : 1)) begin
                failures++;
                $display("FAIL rand_latency op=%0d got %0d exp %0d", o, lat, (o == 3'd6) ? 9 : 1);
            end
            checks++;
            if ({out_valid, result, zero, carry_out, overflow} !== {1'b1, exp_v}) begin
                failures++;
                $display("FAIL rand_result op=%0d a=%h b=%h got ov=%b res=%h z=%b c=%b v=%b exp res=%h z=%b c=%b v=%b",
                         o, x, y, out_valid, result, zero, carry_out, overflow,
                         exp_v[10:3], exp_v[2], exp_v[1], exp_v[0]);
            end
            stall = $urandom_range(0, 3);
            bad = 0;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                if ({out_valid, result, zero, carry_out, overflow} !== {1'b1, exp_v}) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL rand_hold op=%0d got %0d unstable cycles exp 0", o, bad);
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [7:0]  x, y;
        logic [10:0] prev_exp;
        out_ready = 1'b1;
        prev_exp = '0;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                checks++;
                if ({out_valid, in_ready, result, zero, carry_out, overflow} !== {1'b1, 1'b1, prev_exp}) begin
                    failures++;
                    $display("FAIL b2b_%0d got ov=%b rdy=%b res=%h z=%b c=%b v=%b exp ov=1 rdy=1 res=%h z=%b c=%b v=%b",
                             i, out_valid, in_ready, result, zero, carry_out, overflow,
                             prev_exp[10:3], prev_exp[2], prev_exp[1], prev_exp[0]);
                end
            end
            if (i == 8) break;
            o = 3'($urandom_range(0, 6));
            if (o == 3'd6) o = 3'd7;
            x = pick_operand(); y = pick_operand();
            prev_exp = model(o, x, y);
            drive(o, x, y);
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_slt();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
